check_node_sorted_buffer: RTL
=============================

# check_node_sorted_buffer

Sequential insertion-sort buffer for the NB-LDPC check-node path. It accepts a stream of (reliability, symbol) candidates, keeps the DEPTH smallest reliabilities in ascending order, and then drains them in ascending order over a valid/ready handshake to the next check-node stage. The write side uses strict less-than placement per cell; the read side pops the minimum first.

## Interface
Parameters:
- Width, 5: MSB index of reliability; reliability is Width+1 bits, unsigned, smaller means more reliable.
- SymW, 6: symbol (GF index) width; 6 for GF(64).
- DEPTH, 8: number of list cells; minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  candidate present.
- in_ready  output  1  buffer accepts candidates; high only in FILL.
- in_rel  input  Width+1  candidate reliability.
- in_sym  input  SymW  candidate symbol.
- in_last  input  1  final candidate of the set; qualified by in_valid && in_ready.
- out_valid  output  1  head entry valid; high only in DRAIN.
- out_ready  input  1  downstream accepts.
- out_rel  output  Width+1  head reliability.
- out_sym  output  SymW  head symbol.
- out_last  output  1  head is the final stored entry.
- count  output  log2(DEPTH)+1  number of occupied cells.

## Operation
- States: FILL, DRAIN. Reset state FILL, all cells empty, count = 0.
- FILL: in_ready = 1, out_valid = 0. On accept, candidate goes to the lowest index i where cell i is empty or in_rel < rel[i] (strict). Cells i..DEPTH-2 shift to i+1. Cell DEPTH-1 is dropped when full.
- If no such i exists (list full, in_rel ≥ rel[DEPTH-1]), the candidate is discarded and the list is unchanged.
- count saturates at DEPTH.
- Ties: a new entry goes after existing equal entries, so arrival order is preserved among equals.
- An accepted candidate with in_last = 1 is inserted, then the state moves to DRAIN.
- DRAIN: in_ready = 0. out_* reflect cell 0. out_valid = 1 while count > 0. out_last = (count == 1).
- On out_valid && out_ready, cells shift down by one (cell i ← cell i+1, top cell becomes empty) and count decrements.
- Popping the out_last entry returns the state to FILL with an empty list.
- An in_last with a discarded candidate still moves to DRAIN.
- Empty cells compare as +infinity and are never output.
- Reset asserted mid-FILL or mid-DRAIN clears all cells immediately, sets count = 0, and forces FILL. Any partial set is lost.

## Timing
- Output reset values: in_ready = 1, out_valid = 0, out_rel = 0, out_sym = 0, out_last = 0, count = 0.
- Insertion: 1 cycle. A candidate accepted at edge k is visible in the cells and count after edge k. Back-to-back accepts every cycle are supported.
- DRAIN entry: out_valid rises the cycle after the edge that accepted in_last.
- Drain throughput: 1 entry per cycle while out_ready = 1. out_* stay stable while out_valid && !out_ready.
- FILL re-entry: in_ready rises the cycle after the edge that popped the out_last entry.
- out_* are registered, with no combinational path from inputs to outputs.
- in_ready depends only on state.

## Structure
- Shared package holds:
  - reliability width (Width+1) and SymW;
  - DEPTH;
  - the state encoding (FILL, DRAIN);
  - the empty-cell "infinite" marker convention (per-cell occupied bit).
- One sub-module, sorted_list_cell, instantiated DEPTH times. Each instance holds:
  - occupied bit, rel and sym registers;
  - the strict less-than compare against in_rel;
  - the mux for hold / load new / take from the lower neighbour (insert shift) / take from the upper neighbour (pop shift).
- The top level holds the FSM, count, and the one-hot/thermometer insert-position decode built from the cell compare outputs.

## Test plan
- Fill: insert rel 9,3,7,1,5 (sym 0..4), last on 5 → drain order rel 1,3,5,7,9 (sym 3,1,4,2,0), out_last on rel 9, count 5→0.
- Overflow (DEPTH = 8): insert rel 20 down to 10 (11 entries), last on 10 → drain rel 10..17 (8 entries). Also, with the list full of rel 10..17, inserting rel 25 is discarded.
- Ties: insert rel 4 (sym 1), rel 4 (sym 2), rel 4 (sym 3) → drain sym 1,2,3.
- Back-pressure: during drain, hold out_ready = 0 for 3 cycles → out_rel/out_sym unchanged, count unchanged. Then release → one pop per cycle.
- Single-entry set: insert rel 31 with in_last → next cycle out_valid = 1 and out_last = 1. After the pop, in_ready = 1 on the following cycle.
- Reset mid-drain: assert rst_n = 0 after 2 of 5 pops → out_valid = 0, count = 0, in_ready = 1 asynchronously. A new set after release drains correctly.

Source files
------------

// File: rtl/check_node_sorted_buffer_pkg.sv
// rtl/check_node_sorted_buffer_pkg.sv - shared widths, depth and encodings for the sorted buffer
package check_node_sorted_buffer_pkg;

  localparam int CNSB_WIDTH = 5;
  localparam int CNSB_REL_W = CNSB_WIDTH + 1;
  localparam int CNSB_SYM_W = 6;
  localparam int CNSB_DEPTH = 8;
  localparam int CNSB_CNT_W = $clog2(CNSB_DEPTH) + 1;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    CELL_HOLD       = 2'd0,
    CELL_LOAD       = 2'd1,
    CELL_FROM_LOWER = 2'd2,
    CELL_FROM_UPPER = 2'd3
  } cell_op_t;

  // An empty cell acts as +infinity: it wins every compare and is never output.
  localparam logic CELL_EMPTY    = 1'b0;
  localparam logic CELL_OCCUPIED = 1'b1;

endpackage

// File: rtl/check_node_sorted_buffer_if.sv
// rtl/check_node_sorted_buffer_if.sv - candidate input and sorted output handshake bundle
interface check_node_sorted_buffer_if
  import check_node_sorted_buffer_pkg::*;
#(
  parameter int RelW = CNSB_REL_W,
  parameter int SymW = CNSB_SYM_W,
  parameter int CntW = CNSB_CNT_W
);
  logic            in_valid;
  logic            in_ready;
  logic [RelW-1:0] in_rel;
  logic [SymW-1:0] in_sym;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [RelW-1:0] out_rel;
  logic [SymW-1:0] out_sym;
  logic            out_last;
  logic [CntW-1:0] count;

  modport master (
    output in_valid, in_rel, in_sym, in_last, out_ready,
    input  in_ready, out_valid, out_rel, out_sym, out_last, count
  );

  modport slave (
    input  in_valid, in_rel, in_sym, in_last, out_ready,
    output in_ready, out_valid, out_rel, out_sym, out_last, count
  );
endinterface

// File: rtl/check_node_sorted_buffer_sorted_list_cell.sv
// rtl/check_node_sorted_buffer_sorted_list_cell.sv - one list cell: storage, compare and shift mux
module sorted_list_cell
  import check_node_sorted_buffer_pkg::*;
#(
  parameter int RelW = CNSB_REL_W,
  parameter int SymW = CNSB_SYM_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  cell_op_t        op,
  input  logic [RelW-1:0] in_rel,
  input  logic [SymW-1:0] in_sym,
  input  logic            lower_occ,
  input  logic [RelW-1:0] lower_rel,
  input  logic [SymW-1:0] lower_sym,
  input  logic            upper_occ,
  input  logic [RelW-1:0] upper_rel,
  input  logic [SymW-1:0] upper_sym,
  output logic            occ,
  output logic [RelW-1:0] rel,
  output logic [SymW-1:0] sym,
  output logic            lt
);

  // Strict compare keeps equal reliabilities in arrival order.
  assign lt = (occ == CELL_EMPTY) || (in_rel < rel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= CELL_EMPTY;
      rel <= '0;
      sym <= '0;
    end else begin
      case (op)
        CELL_LOAD: begin
          occ <= CELL_OCCUPIED;
          rel <= in_rel;
          sym <= in_sym;
        end
        CELL_FROM_LOWER: begin
          occ <= lower_occ;
          rel <= lower_rel;
          sym <= lower_sym;
        end
        CELL_FROM_UPPER: begin
          occ <= upper_occ;
          rel <= upper_rel;
          sym <= upper_sym;
        end
        default: begin
          occ <= occ;
          rel <= rel;
          sym <= sym;
        end
      endcase
    end
  end

endmodule

// File: rtl/check_node_sorted_buffer.sv
// rtl/check_node_sorted_buffer.sv - insertion-sort buffer keeping the DEPTH smallest reliabilities
module check_node_sorted_buffer
  import check_node_sorted_buffer_pkg::*;
#(
  parameter int Width = CNSB_WIDTH,
  parameter int SymW  = CNSB_SYM_W,
  parameter int DEPTH = CNSB_DEPTH
) (
  input logic                        clk,
  input logic                        rst_n,
  check_node_sorted_buffer_if.slave  bus
);

  localparam int RelW = Width + 1;
  localparam int CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DEPTH_CNT = CntW'(DEPTH);
  localparam logic [CntW-1:0] ONE_CNT   = CntW'(1);

  state_t          state_q, state_d;
  logic [CntW-1:0] count_q;
  logic [DEPTH-1:0] therm;
  logic [DEPTH-1:0] therm_lo;
  logic [DEPTH-1:0] sel;
  logic            accept;
  logic            pop;

  logic            cell_occ [DEPTH];
  logic [RelW-1:0] cell_rel [DEPTH];
  logic [SymW-1:0] cell_sym [DEPTH];
  cell_op_t        cell_op  [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic            lo_occ, up_occ;
    logic [RelW-1:0] lo_rel, up_rel;
    logic [SymW-1:0] lo_sym, up_sym;

    if (i == 0) begin : g_bottom
      assign lo_occ = CELL_EMPTY;
      assign lo_rel = '0;
      assign lo_sym = '0;
    end else begin : g_lower
      assign lo_occ = cell_occ[i-1];
      assign lo_rel = cell_rel[i-1];
      assign lo_sym = cell_sym[i-1];
    end

    if (i == DEPTH - 1) begin : g_top
      assign up_occ = CELL_EMPTY;
      assign up_rel = '0;
      assign up_sym = '0;
    end else begin : g_upper
      assign up_occ = cell_occ[i+1];
      assign up_rel = cell_rel[i+1];
      assign up_sym = cell_sym[i+1];
    end

    sorted_list_cell #(
      .RelW (RelW),
      .SymW (SymW)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .op        (cell_op[i]),
      .in_rel    (bus.in_rel),
      .in_sym    (bus.in_sym),
      .lower_occ (lo_occ),
      .lower_rel (lo_rel),
      .lower_sym (lo_sym),
      .upper_occ (up_occ),
      .upper_rel (up_rel),
      .upper_sym (up_sym),
      .occ       (cell_occ[i]),
      .rel       (cell_rel[i]),
      .sym       (cell_sym[i]),
      .lt        (therm[i])
    );
  end

  // The list is sorted with empties on top, so the compare bits form a thermometer;
  // its lowest set bit is the insert position and everything above it shifts up.
  assign therm_lo = {therm[DEPTH-2:0], 1'b0};
  assign sel      = therm & ~therm_lo;

  assign accept = bus.in_valid && (state_q == ST_FILL);
  assign pop    = bus.out_ready && bus.out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < DEPTH; i++) begin
      cell_op[i] = CELL_HOLD;
    end
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
              cell_op[i] = CELL_LOAD;
            end else if (therm[i]) begin
              cell_op[i] = CELL_FROM_LOWER;
            end
          end
          if (bus.in_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop) begin
          for (int i = 0; i < DEPTH; i++) begin
            cell_op[i] = CELL_FROM_UPPER;
          end
          if (count_q == ONE_CNT) begin
            state_d = ST_FILL;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (accept && (|therm) && (count_q != DEPTH_CNT)) begin
      count_q <= count_q + ONE_CNT;
    end else if ((state_q == ST_DRAIN) && pop) begin
      count_q <= count_q - ONE_CNT;
    end
  end

  assign bus.in_ready  = (state_q == ST_FILL);
  assign bus.out_valid = (state_q == ST_DRAIN) && (count_q != '0);
  assign bus.out_rel   = cell_rel[0];
  assign bus.out_sym   = cell_sym[0];
  assign bus.out_last  = (state_q == ST_DRAIN) && (count_q == ONE_CNT);
  assign bus.count     = count_q;

endmodule
